rr_arbiter_mux: RTL

RR_ARBITER_MUX -- requirements
Module: rr_arbiter_mux

---
 rtl/rr_arbiter_mux_pkg.sv | 13 +
 rtl/rr_arbiter_mux_decoded.sv | 24 ++
 rtl/rr_arbiter_mux.sv | 92 +++++++++
 3 files changed

// File: rtl/rr_arbiter_mux_pkg.sv
// Shared constants and helpers for the round-robin arbiter/mux slice.
// Holds the default geometry and the pointer-width rule used by the top.
package rr_arbiter_mux_pkg;

    localparam int DEFAULT_WAY_WIDTH = 4;
    localparam int DEFAULT_NUM_WAY   = 8;

    // Pointer width never drops to zero, so a 2-way instance still gets one bit.
    function automatic int index_width(input int num_way);
        return (num_way <= 2) ? 1 : $clog2(num_way);
    endfunction

endpackage

// File: rtl/rr_arbiter_mux_decoded.sv
// One-hot selected multiplexer: returns the slice of the flattened input
// picked by a one-hot select; unselected slices never reach the output.
module mux_decoded
    import rr_arbiter_mux_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WAY_WIDTH,
    parameter int NUM_WAY = DEFAULT_NUM_WAY
) (
    input  logic [WIDTH*NUM_WAY-1:0] way_data,
    input  logic [NUM_WAY-1:0]       select,
    output logic [WIDTH-1:0]         selected
);

    // Gating on the select bit keeps unknowns on idle ways out of the result.
    always_comb begin
        selected = '0;
        for (int i = 0; i < NUM_WAY; i++) begin
            if (select[i]) begin
                selected = selected | way_data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_mux.sv
// Round-robin arbiter feeding a one-entry registered output stage.
// The winning way's payload and one-hot grant are captured on each load.
module rr_arbiter_mux
    import rr_arbiter_mux_pkg::*;
#(
    parameter int SINGLE_WAY_WIDTH_IN_BITS = DEFAULT_WAY_WIDTH,
    parameter int NUM_WAY                  = DEFAULT_NUM_WAY
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_in,
    input  logic [NUM_WAY-1:0]                    way_valid_in,
    output logic [NUM_WAY-1:0]                    way_ready_out,
    output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]   way_flatted_out,
    output logic                                  valid_out,
    input  logic                                  ready_in,
    output logic [NUM_WAY-1:0]                    grant_out
);

    localparam int PTR_W = index_width(NUM_WAY);
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NUM_WAY - 1);

    logic [PTR_W-1:0]                    last_grant_ptr;
    logic [2*NUM_WAY-1:0]                req_double;
    logic [2*NUM_WAY-1:0]                req_masked;
    logic [NUM_WAY-1:0]                  grant;
    logic [PTR_W-1:0]                    grant_idx;
    logic [SINGLE_WAY_WIDTH_IN_BITS-1:0] selected_payload;
    logic                                any_request;
    logic                                load;
    int                                  win_idx;

    assign any_request = |way_valid_in;
    assign load        = (!valid_out || ready_in) && any_request;

    // Doubling the request vector lets a single lowest-bit search above the
    // pointer cover the wrap-around; the upper copy always contains every way.
    always_comb begin
        req_double = {way_valid_in, way_valid_in};
        req_masked = '0;
        for (int i = 0; i < 2*NUM_WAY; i++) begin
            if (i > int'(last_grant_ptr)) begin
                req_masked[i] = req_double[i];
            end
        end
        win_idx = 0;
        for (int i = 2*NUM_WAY-1; i >= 0; i--) begin
            if (req_masked[i]) begin
                win_idx = i;
            end
        end
        if (win_idx >= NUM_WAY) begin
            win_idx = win_idx - NUM_WAY;
        end
        grant = '0;
        for (int j = 0; j < NUM_WAY; j++) begin
            if (any_request && (j == win_idx)) begin
                grant[j] = 1'b1;
            end
        end
        grant_idx = PTR_W'(win_idx);
    end

    assign way_ready_out = (load && !reset_in) ? grant : '0;

    mux_decoded #(
        .WIDTH   (SINGLE_WAY_WIDTH_IN_BITS),
        .NUM_WAY (NUM_WAY)
    ) u_mux (
        .way_data (way_flatted_in),
        .select   (grant),
        .selected (selected_payload)
    );

    // Output stage: capture on load, retire on a drained accept, otherwise hold.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            valid_out       <= 1'b0;
            way_flatted_out <= '0;
            grant_out       <= '0;
            last_grant_ptr  <= PTR_RESET;
        end else if (load) begin
            valid_out       <= 1'b1;
            way_flatted_out <= selected_payload;
            grant_out       <= grant;
            last_grant_ptr  <= grant_idx;
        end else if (ready_in) begin
            valid_out       <= 1'b0;
        end
    end

endmodule
